// File: rtl/mips_controller.sv
// mips_controller: multicycle control FSM for the 8-bit MIPS core.
// It sequences a 4-byte fetch, then decode and execute. It drives every
// datapath select and enable, plus the 3-bit alucont code consumed by the ALU.
// The datapath outputs are Moore outputs, registered together with the state.
// Two outputs also look at inputs in the current cycle:
//   pcen    = pcwrite | (branch & zero)
//   alucont = decoded from funct while in RTYPEEX.
// Optional feature macro: CTRL_ADDI_EN (adds the ADDIEX/ADDIWR path for addi).
module mips_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       iord,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic [1:0] pcsource,
    output logic [1:0] alusrcb,
    output logic [3:0] irwrite,
    output logic [2:0] alucont
);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH1,
        FETCH2,
        FETCH3,
        FETCH4,
        DECODE,
        MEMADR,
        LBRD,
        LBWR,
        SBWR,
        RTYPEEX,
        RTYPEWR,
        BEQEX,
        JEX
`ifdef CTRL_ADDI_EN
        ,
        ADDIEX,
        ADDIWR
`endif
    } state_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [3:0] irwrite;
        logic [2:0] alucont;
    } ctrl_t;

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;
    logic [2:0] funct_alucont;

    // Per-state Moore decode. Anything not named for a state stays 0,
    // except alucont, which defaults to ADD.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        c.alucont = ALU_ADD;
        case (s)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                c.pcwrite = 1'b1;
                c.pcsource = 2'b00;
                case (s)
                    FETCH1:  c.irwrite = 4'b0001;
                    FETCH2:  c.irwrite = 4'b0010;
                    FETCH3:  c.irwrite = 4'b0100;
                    default: c.irwrite = 4'b1000;
                endcase
            end
            DECODE: begin
                // Branch target is computed early into ALUOut.
                c.alusrcb = 2'b11;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            LBRD: begin
                c.memread = 1'b1;
                c.iord = 1'b1;
            end
            LBWR: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            SBWR: begin
                c.memwrite = 1'b1;
                c.iord = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b00;
            end
            RTYPEWR: begin
                c.regwrite = 1'b1;
                c.regdst = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b00;
                c.alucont = ALU_SUB;
                c.branch = 1'b1;
                c.pcsource = 2'b01;
            end
            JEX: begin
                c.pcwrite = 1'b1;
                c.pcsource = 2'b10;
            end
`ifdef CTRL_ADDI_EN
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWR: begin
                c.regwrite = 1'b1;
            end
`endif
            default: c = c;
        endcase
        return c;
    endfunction

    // Next-state logic. Unrecognised opcodes fall straight back to FETCH1
    // from DECODE, so they have no side effects.
    always_comb begin
        state_next = FETCH1;
        case (state_reg)
            FETCH1: state_next = FETCH2;
            FETCH2: state_next = FETCH3;
            FETCH3: state_next = FETCH4;
            FETCH4: state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_J:         state_next = JEX;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      state_next = ADDIEX;
`endif
                    default:      state_next = FETCH1;
                endcase
            end
            MEMADR:  state_next = (op == OP_SB) ? SBWR : LBRD;
            LBRD:    state_next = LBWR;
            RTYPEEX: state_next = RTYPEWR;
`ifdef CTRL_ADDI_EN
            ADDIEX:  state_next = ADDIWR;
`endif
            default: state_next = FETCH1;
        endcase
    end

    // ALU operation selected by funct for R-type execute.
    always_comb begin
        case (funct)
            6'b100000: funct_alucont = ALU_ADD;
            6'b100010: funct_alucont = ALU_SUB;
            6'b100100: funct_alucont = ALU_AND;
            6'b100101: funct_alucont = ALU_OR;
            6'b101010: funct_alucont = ALU_SLT;
            default:   funct_alucont = ALU_ADD;
        endcase
    end

    // State register with outputs registered alongside it. Reset loads the
    // FETCH1 decode at once, so outputs show FETCH1 while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH1;
            ctrl_reg  <= decode_state(FETCH1);
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decode_state(state_next);
        end
    end

    assign memread  = ctrl_reg.memread;
    assign memwrite = ctrl_reg.memwrite;
    assign alusrca  = ctrl_reg.alusrca;
    assign memtoreg = ctrl_reg.memtoreg;
    assign iord     = ctrl_reg.iord;
    assign regwrite = ctrl_reg.regwrite;
    assign regdst   = ctrl_reg.regdst;
    assign pcsource = ctrl_reg.pcsource;
    assign alusrcb  = ctrl_reg.alusrcb;
    assign irwrite  = ctrl_reg.irwrite;
    assign pcen     = ctrl_reg.pcwrite | (ctrl_reg.branch & zero);
    assign alucont  = (state_reg == RTYPEEX) ? funct_alucont : ctrl_reg.alucont;

endmodule

// File: tb/tb_mips_controller.sv
// tb_mips_controller: directed bench for mips_controller.
// For each instruction, the expected per-cycle outputs are pushed into a
// scoreboard queue. They are then popped and compared once per cycle at the
// falling edge. Build with +define+CTRL_ADDI_EN to check the addi path.
module tb_mips_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
    logic [1:0] pcsource, alusrcb;
    logic [3:0] irwrite;
    logic [2:0] alucont;

    int checks = 0;
    int failures = 0;

    // Bench-side state numbering for the expected-output model.
    localparam int S_F1 = 0, S_F2 = 1, S_F3 = 2, S_F4 = 3, S_DEC = 4, S_MEMADR = 5,
                   S_LBRD = 6, S_LBWR = 7, S_SBWR = 8, S_REX = 9, S_RWR = 10,
                   S_BEQ = 11, S_JEX = 12, S_AEX = 13, S_AWR = 14;

    typedef struct {
        int          st;
        logic [18:0] vec;
    } exp_t;

    exp_t sb_q[$];

    mips_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca),
        .memtoreg(memtoreg), .iord(iord), .pcen(pcen), .regwrite(regwrite),
        .regdst(regdst), .pcsource(pcsource), .alusrcb(alusrcb),
        .irwrite(irwrite), .alucont(alucont)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [18:0] pack(
        input logic mr, mw, asa, m2r, io, pce, rw, rd,
        input logic [1:0] pcs, asb, input logic [3:0] irw, input logic [2:0] ac);
        return {mr, mw, asa, m2r, io, pce, rw, rd, pcs, asb, irw, ac};
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected outputs for a state. Arguments to pack(), in order:
    //   memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst,
    //   pcsource, alusrcb, irwrite, alucont
    function automatic logic [18:0] model(input int st, input logic [5:0] f, input logic z);
        case (st)
            S_F1:     return pack(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 4'b0001, 3'b010);
            S_F2:     return pack(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 4'b0010, 3'b010);
            S_F3:     return pack(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 4'b0100, 3'b010);
            S_F4:     return pack(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 4'b1000, 3'b010);
            S_DEC:    return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 4'b0000, 3'b010);
            S_MEMADR: return pack(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0000, 3'b010);
            S_LBRD:   return pack(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b010);
            S_LBWR:   return pack(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 3'b010);
            S_SBWR:   return pack(0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b010);
            S_REX:    return pack(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, funct_op(f));
            S_RWR:    return pack(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 4'b0000, 3'b010);
            S_BEQ:    return pack(0, 0, 1, 0, 0, z, 0, 0, 2'b01, 2'b00, 4'b0000, 3'b110);
            S_JEX:    return pack(0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 4'b0000, 3'b010);
            S_AEX:    return pack(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0000, 3'b010);
            S_AWR:    return pack(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 3'b010);
            default:  return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [18:0] expv);
        logic [18:0] obs;
        obs = {memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst,
               pcsource, alusrcb, irwrite, alucont};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drive one instruction, push its expected cycle sequence, then pop and
    // compare one entry per cycle. It must be called at a falling edge with
    // the DUT in FETCH1. A nonzero limit stops after that many cycles and
    // stays in the last one, so reset can land inside an instruction.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int limit);
        int seq[$];
        exp_t e;
        op = o;
        funct = f;
        zero = z;
        seq = '{S_F1, S_F2, S_F3, S_F4, S_DEC};
        case (o)
            6'b100000: seq = {seq, S_MEMADR, S_LBRD, S_LBWR};
            6'b101000: seq = {seq, S_MEMADR, S_SBWR};
            6'b000000: seq = {seq, S_REX, S_RWR};
            6'b000100: seq = {seq, S_BEQ};
            6'b000010: seq = {seq, S_JEX};
`ifdef CTRL_ADDI_EN
            6'b001000: seq = {seq, S_AEX, S_AWR};
`endif
            default:   seq = seq;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (limit == 0 || i < limit) begin
                e.st = seq[i];
                e.vec = model(seq[i], f, z);
                sb_q.push_back(e);
            end
        end
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check($sformatf("%s op=%b funct=%h zero=%0d state=%0d", name, o, f, z, e.st), e.vec);
            if (sb_q.size() != 0) @(negedge clk);
        end
        $display("txn %s op=%b funct=%h zero=%0d cycles=%0d", name, o, f, z,
                 (limit == 0) ? seq.size() : limit);
        if (limit == 0) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        op = 6'b0;
        funct = 6'b0;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_held", model(S_F1, 6'h0, 1'b0));
        reset = 1'b0;

        run_instr("lb", 6'b100000, 6'h00, 1'b0, 0);
        run_instr("sb", 6'b101000, 6'h00, 1'b1, 0);
        run_instr("radd", 6'b000000, 6'h20, 1'b0, 0);
        run_instr("rsub", 6'b000000, 6'h22, 1'b0, 0);
        run_instr("rand", 6'b000000, 6'h24, 1'b1, 0);
        run_instr("ror", 6'b000000, 6'h25, 1'b0, 0);
        run_instr("rslt", 6'b000000, 6'h2A, 1'b0, 0);
        run_instr("rother", 6'b000000, 6'h07, 1'b0, 0);
        run_instr("beq_taken", 6'b000100, 6'h00, 1'b1, 0);
        run_instr("beq_not", 6'b000100, 6'h00, 1'b0, 0);
        run_instr("j", 6'b000010, 6'h00, 1'b0, 0);
        run_instr("addi", 6'b001000, 6'h00, 1'b0, 0);
        run_instr("illegal", 6'b111111, 6'h00, 1'b1, 0);

        // Reset asserted mid-RTYPEEX must take effect without a clock edge.
        run_instr("rst_mid", 6'b000000, 6'h22, 1'b0, 6);
        #2 reset = 1'b1;
        #1 check("reset_async", model(S_F1, 6'h0, 1'b0));
        @(negedge clk);
        check("reset_hold_edge", model(S_F1, 6'h0, 1'b0));
        reset = 1'b0;
        $display("txn reset_mid_rtypeex");

        run_instr("lb_after_rst", 6'b100000, 6'h00, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
